// File: rtl/tt_vector_checker.sv
// Stimulus player and masked response checker: stores vectors, drives them onto a DUT
// input bus one per cycle, and scores the DUT output LAT cycles later.
module tt_vector_checker #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int DEPTH = 16,
    parameter int LAT   = 1,
    parameter int CNT_W = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [IN_W-1:0]  ld_stim,
    input  logic [OUT_W-1:0] ld_exp,
    input  logic [OUT_W-1:0] ld_mask,
    input  logic             start,
    input  logic             loop,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [1:0]       dbg_state
);

    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] FULL    = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Vector store; contents are only ever read while replaying a run.
    logic [IN_W-1:0]  mem_stim [DEPTH];
    logic [OUT_W-1:0] mem_exp  [DEPTH];
    logic [OUT_W-1:0] mem_mask [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] run_len;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] last_idx;
    logic             loop_q;
    logic             err_seen;
    logic [OUT_W-1:0] cur_exp;
    logic [OUT_W-1:0] cur_mask;

    // Compare pipe: stage j holds the vector that was on dut_in j+1 cycles ago.
    logic [LAT-1:0]   pv;
    logic [OUT_W-1:0] pe   [LAT];
    logic [OUT_W-1:0] pm   [LAT];
    logic [IDX_W-1:0] pidx [LAT];

    logic             busy_w;
    logic             ld_fire;
    logic             do_clear;
    logic             do_start;
    logic             at_last;
    logic             drain_pending;
    logic             mismatch;
    logic             fetch_en;
    logic             fetch_byp;
    logic [IDX_W-1:0] fetch_idx;

    // Load handshake: a vector is written on every rising edge where ld_valid && ld_ready;
    // ld_ready never depends on ld_valid, and ld_* must be stable while ld_valid is high.
    assign busy_w   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign ld_ready = !busy_w && (wr_ptr != FULL);
    assign ld_fire  = ld_valid && ld_ready;
    assign do_clear = clear && !busy_w;
    assign do_start = start && !busy_w && !clear;
    assign run_len  = wr_ptr + {{IDX_W{1'b0}}, ld_fire};
    assign at_last  = (rd_idx == last_idx);
    assign mismatch = pv[LAT-1] && (|((dut_out ^ pe[LAT-1]) & pm[LAT-1]));

    assign busy      = busy_w;
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_count == '0);
    assign dbg_state = state_q;

    always_comb begin
        drain_pending = 1'b0;
        for (int j = 0; j < LAT - 1; j++) begin
            drain_pending = drain_pending | pv[j];
        end
    end

    always_comb begin
        state_d   = state_q;
        fetch_en  = 1'b0;
        fetch_byp = 1'b0;
        fetch_idx = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (do_clear) begin
                    state_d = S_IDLE;
                end else if (do_start) begin
                    if (run_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                        fetch_en  = 1'b1;
                        // Vector 0 may be the one being loaded this very cycle.
                        fetch_byp = (wr_ptr == '0);
                    end
                end
            end
            S_RUN: begin
                if (at_last) begin
                    state_d = S_DRAIN;
                end else begin
                    fetch_en  = 1'b1;
                    fetch_idx = rd_idx + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if (!drain_pending) begin
                    if (loop_q) begin
                        state_d  = S_RUN;
                        fetch_en = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem_stim[wr_ptr[IDX_W-1:0]] <= ld_stim;
            mem_exp[wr_ptr[IDX_W-1:0]]  <= ld_exp;
            mem_mask[wr_ptr[IDX_W-1:0]] <= ld_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_idx        <= '0;
            last_idx      <= '0;
            loop_q        <= 1'b0;
            dut_in        <= '0;
            cur_exp       <= '0;
            cur_mask      <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            err_seen      <= 1'b0;
            pv            <= '0;
            for (int j = 0; j < LAT; j++) begin
                pe[j]   <= '0;
                pm[j]   <= '0;
                pidx[j] <= '0;
            end
        end else begin
            if (do_clear) begin
                wr_ptr <= '0;
            end else if (ld_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (fetch_en) begin
                rd_idx <= fetch_idx;
                if (fetch_byp) begin
                    dut_in   <= ld_stim;
                    cur_exp  <= ld_exp;
                    cur_mask <= ld_mask;
                end else begin
                    dut_in   <= mem_stim[fetch_idx];
                    cur_exp  <= mem_exp[fetch_idx];
                    cur_mask <= mem_mask[fetch_idx];
                end
            end else if (do_clear) begin
                dut_in <= '0;
            end

            // Loop re-entry goes DRAIN->RUN without passing here, so results accumulate.
            if (do_start) begin
                loop_q        <= loop;
                last_idx      <= IDX_W'(run_len - PTR_W'(1));
                err_count     <= '0;
                first_err_idx <= '0;
                err_seen      <= 1'b0;
            end else if (do_clear) begin
                err_count     <= '0;
                first_err_idx <= '0;
                err_seen      <= 1'b0;
            end

            pv[0]   <= (state_q == S_RUN);
            pe[0]   <= cur_exp;
            pm[0]   <= cur_mask;
            pidx[0] <= rd_idx;
            for (int j = 1; j < LAT; j++) begin
                pv[j]   <= pv[j-1];
                pe[j]   <= pe[j-1];
                pm[j]   <= pm[j-1];
                pidx[j] <= pidx[j-1];
            end

            // The pipe is empty whenever start/clear can act, so no clash with the above.
            if (mismatch) begin
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (!err_seen) begin
                    err_seen      <= 1'b1;
                    first_err_idx <= pidx[LAT-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_vector_checker.sv
// Bench for tt_vector_checker: directed vectors against a transaction-level model of the
// run timeline, checked every cycle, plus hand-computed literal expectations.
module tb_tt_vector_checker;

    localparam int IN_W    = 8;
    localparam int OUT_W   = 8;
    localparam int DEPTH   = 8;
    localparam int LAT     = 1;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             clear = 1'b0;
    logic             ld_valid = 1'b0;
    logic [IN_W-1:0]  ld_stim = '0;
    logic [OUT_W-1:0] ld_exp = '0;
    logic [OUT_W-1:0] ld_mask = '0;
    logic             start = 1'b0;
    logic             loop = 1'b0;
    logic             ld_ready;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [IDX_W-1:0] first_err_idx;
    logic [1:0]       dbg_state;

    tt_vector_checker #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_stim(ld_stim), .ld_exp(ld_exp), .ld_mask(ld_mask),
        .start(start), .loop(loop),
        .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .dbg_state(dbg_state)
    );

    // Design under test stand-in: one register, output = input + 1.
    logic [OUT_W-1:0] dut_reg = '0;
    always @(posedge clk) dut_reg <= rst ? 8'h00 : dut_in + 8'h01;
    assign dut_out = dut_reg;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] s_stim [DEPTH];
    logic [7:0] s_exp  [DEPTH];
    logic [7:0] s_mask [DEPTH];
    int         m_cnt = 0;
    logic [7:0] r_stim [DEPTH];
    bit         r_mis  [DEPTH];
    int         m_n = 0;
    int         m_c = 0;
    bit         m_loop = 1'b0;
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    int         m_err = 0;
    int         m_first = 0;
    logic [7:0] m_dut_in = '0;
    logic [IN_W-1:0] exp_q[$];

    // Global cycle g of a run plays vector g % (n+LAT) (drain slots excluded); it is
    // scored at the end of cycle g+LAT, so visible from cycle g+LAT+1.
    function automatic int err_at(input int c);
        int cnt = 0;
        for (int g = 0; g + LAT < c; g++) begin
            int k = g % (m_n + LAT);
            if (k < m_n && r_mis[k]) cnt++;
        end
        return (cnt > CNT_MAX) ? CNT_MAX : cnt;
    endfunction

    function automatic int first_at(input int c);
        for (int g = 0; g + LAT < c; g++) begin
            int k = g % (m_n + LAT);
            if (k < m_n && r_mis[k]) return k;
        end
        return 0;
    endfunction

    task automatic push_pass();
        for (int k = 0; k < m_n; k++) exp_q.push_back(r_stim[k]);
        for (int d = 0; d < LAT; d++) exp_q.push_back(r_stim[m_n-1]);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_active = 1'b0; m_done = 1'b0; m_err = 0; m_first = 0;
            m_dut_in = '0; m_loop = 1'b0;
            exp_q.delete();
        end else if (m_active) begin
            m_c++;
            if (m_c % (m_n + LAT) == 0) begin
                if (m_loop) begin
                    push_pass();
                end else begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_err    = err_at(m_c);
                    m_first  = first_at(m_c);
                    m_dut_in = r_stim[m_n-1];
                end
            end
        end else if (clear) begin
            m_cnt = 0; m_done = 1'b0; m_err = 0; m_first = 0; m_dut_in = '0;
        end else begin
            if (ld_valid && m_cnt < DEPTH) begin
                s_stim[m_cnt] = ld_stim;
                s_exp[m_cnt]  = ld_exp;
                s_mask[m_cnt] = ld_mask;
                m_cnt++;
            end
            if (start) begin
                m_n = m_cnt;
                m_err = 0;
                m_first = 0;
                if (m_n == 0) begin
                    m_done = 1'b1;
                end else begin
                    for (int k = 0; k < m_n; k++) begin
                        logic [7:0] resp;
                        resp = s_stim[k] + 8'h01;
                        r_stim[k] = s_stim[k];
                        r_mis[k]  = ((resp ^ s_exp[k]) & s_mask[k]) != 8'h00;
                    end
                    m_loop = loop;
                    m_active = 1'b1;
                    m_c = 0;
                    m_done = 1'b0;
                    push_pass();
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_active) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 32'd1, 32'd0);
                end else begin
                    check("run_dut_in", dut_in, exp_q.pop_front());
                end
                check("run_busy", busy, 1);
                check("run_done", done, 0);
                check("run_pass", pass, 0);
                check("run_ld_ready", ld_ready, 0);
                check("run_err_count", err_count, err_at(m_c));
                check("run_first_err", first_err_idx, first_at(m_c));
            end else begin
                check("idle_busy", busy, 0);
                check("idle_done", done, m_done);
                check("idle_pass", pass, (m_done && m_err == 0) ? 1 : 0);
                check("idle_ld_ready", ld_ready, (m_cnt < DEPTH) ? 1 : 0);
                check("idle_dut_in", dut_in, m_dut_in);
                check("idle_err_count", err_count, m_err);
                check("idle_first_err", first_err_idx, m_first);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
        ld_valid = 1'b1; ld_stim = s; ld_exp = e; ld_mask = m;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic run_start(input logic lp);
        start = 1'b1; loop = lp;
        tick();
        start = 1'b0; loop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            n++;
            tick();
        end
        check(name, done, 1);
    endtask

    task automatic count_busy(output int cnt, input bool_start_at1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin
            start = bool_start_at1 && (cnt == 1);
            cnt++;
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_ld_ready", ld_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_dut_in", dut_in, 0);

        // 1: four matching vectors
        for (int i = 0; i < 4; i++) load_vec(8'(i + 1), 8'(i + 2), 8'hFF);
        run_start(1'b0);
        count_busy(cnt, 1'b0);
        check("t1_busy_cycles", cnt, 5);
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);

        // 2: vector 2 wrong, then masked off
        do_clear();
        for (int i = 0; i < 4; i++) load_vec(8'(i + 1), (i == 2) ? 8'h00 : 8'(i + 2), 8'hFF);
        run_start(1'b0);
        wait_done("t2_done", 20);
        check("t2_pass", pass, 0);
        check("t2_err", err_count, 1);
        check("t2_first", first_err_idx, 2);
        do_clear();
        for (int i = 0; i < 4; i++)
            load_vec(8'(i + 1), (i == 2) ? 8'h00 : 8'(i + 2), (i == 2) ? 8'h00 : 8'hFF);
        run_start(1'b0);
        wait_done("t2m_done", 20);
        check("t2m_pass", pass, 1);

        // 3: fill the store, extra load refused
        do_clear();
        for (int i = 0; i < DEPTH; i++) load_vec(8'(8'h10 + i), 8'(8'h11 + i), 8'hFF);
        check("t3_full_ready", ld_ready, 0);
        load_vec(8'hEE, 8'h00, 8'hFF);
        run_start(1'b0);
        wait_done("t3_done", 40);
        check("t3_pass", pass, 1);
        do_clear();
        check("t3_clear_ready", ld_ready, 1);

        // 4: start with empty store
        run_start(1'b0);
        check("t4_done", done, 1);
        check("t4_pass", pass, 1);
        check("t4_dut_in", dut_in, 0);

        // 6: start with same-cycle load, start during run ignored
        do_clear();
        load_vec(8'h21, 8'h22, 8'hFF);
        load_vec(8'h31, 8'h32, 8'hFF);
        start = 1'b1; ld_valid = 1'b1; ld_stim = 8'h41; ld_exp = 8'h42; ld_mask = 8'hFF;
        tick();
        start = 1'b0; ld_valid = 1'b0;
        count_busy(cnt, 1'b1);
        check("t6_busy_cycles", cnt, 4);
        check("t6_pass", pass, 1);

        // 7: start with empty store plus same-cycle load of a mismatching vector
        do_clear();
        start = 1'b1; ld_valid = 1'b1; ld_stim = 8'h55; ld_exp = 8'h00; ld_mask = 8'h0F;
        tick();
        start = 1'b0; ld_valid = 1'b0;
        wait_done("t7_done", 20);
        check("t7_err", err_count, 1);
        check("t7_pass", pass, 0);

        // 5: loop with saturating error count, then reset mid-run
        do_clear();
        load_vec(8'h00, 8'h01, 8'hFF);
        for (int i = 1; i < 4; i++) load_vec(8'(i), 8'hA0, 8'hFF);
        run_start(1'b1);
        repeat (30) tick();
        check("t5_err_sat", err_count, 15);
        check("t5_first", first_err_idx, 1);
        check("t5_not_done", done, 0);
        check("t5_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_pass", pass, 0);
        check("t5_rst_err", err_count, 0);
        check("t5_rst_first", first_err_idx, 0);
        check("t5_rst_dut_in", dut_in, 0);
        check("t5_rst_ready", ld_ready, 1);
        rst = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
